spi_slave_port: RTL and testbench
=================================

Name: spi_slave_port

Overview:
SPI responder (slave) for the laser projector. Lets an external SPI master (a host MCU or a second board running the Beta SPI master) stream command words in and read status words out. All SPI pins are oversampled and synchronised into the system clock domain; no logic runs on SCLK. The core side presents a word-level RX register and a one-deep TX buffer, which the memory-mapped IO block exposes to the Beta.

Parameters:
WIDTH, 32, SPI word length in bits (MSB first); legal range 8..32.
SYNC_STAGES, 2, synchroniser flops per SPI input pin before edge detection; minimum 2.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
spi_sclk  input  1  SPI clock from master; mode 0 (CPOL=0, CPHA=0); max frequency clk/8
spi_csn  input  1  chip select, active low
spi_mosi  input  1  master-out data
spi_miso  output  1  slave-out data
spi_miso_oe  output  1  pad output enable; 1 only while selected
rx_data  output  WIDTH  last complete received word
rx_valid  output  1  rx_data holds an unread word
rx_ack  input  1  core has consumed rx_data
tx_data  input  WIDTH  next word to transmit
tx_load  input  1  write tx_data into TX buffer
tx_ready  output  1  TX buffer empty, tx_load accepted
overrun  output  1  sticky: a word arrived while rx_valid=1
underrun  output  1  sticky: a word started with TX buffer empty
status_clr  input  1  clears overrun and underrun

Behaviour:
- Reset (synchronous): state IDLE, bit count 0, rx_data=0, rx_valid=0, tx_ready=1, TX buffer=0, TX shift=0, overrun=0, underrun=0, spi_miso=0, spi_miso_oe=0. Synchroniser flops reset to idle levels (sclk=0, csn=1, mosi=0).
- Pin path: each pin passes through SYNC_STAGES flops plus one history flop. An edge is detected when sync!=history. With default settings, a pin edge is acted on in the 3rd clk after it and is visible on outputs in the 4th.
- State machine:
  - IDLE: move to ACTIVE on synced CSN fall.
  - ACTIVE: return to IDLE on synced CSN rise.
- Entering ACTIVE:
  - Bit count is set to 0.
  - TX shift loads the TX buffer if it is full, and tx_ready goes to 1. If the buffer is empty, TX shift loads 0 and underrun is set.
- ACTIVE, synced SCLK rise:
  - RX shift takes {rx_shift[WIDTH-2:0], mosi_sync}; count increments.
  - When count reaches WIDTH: count wraps to 0, rx_data takes the completed word, rx_valid is set, and the TX shift is reloaded using the same rule as entering ACTIVE. This gives back-to-back words with CSN held low.
- ACTIVE, synced SCLK fall: if count!=0, TX shift moves left one bit; if count==0, nothing happens.
- spi_miso = TX shift MSB while ACTIVE, else 0. spi_miso_oe = 1 while ACTIVE.
- CSN rise mid-word: the partial RX word is discarded, count returns to 0, rx_data and rx_valid are unchanged, and no flags are raised. The TX word already loaded is lost; it does not return to the buffer.
- rx_ack clears rx_valid. If word completion and rx_ack occur in the same cycle, the new word wins: rx_valid stays 1 and overrun is not set. If a word completes while rx_valid=1 and rx_ack=0, rx_data is overwritten and overrun is set.
- tx_load is accepted only when tx_ready=1; the buffer takes tx_data and tx_ready drops. tx_load while tx_ready=0 is ignored.
- If tx_load and a TX-shift reload occur in the same cycle with the buffer empty: the shift loads 0, underrun is set, the buffer takes tx_data, and tx_ready drops.
- If status_clr and a flag-set event occur in the same cycle, the set wins.
- Reset asserted mid-frame: the block returns to reset values and stays in IDLE until the next CSN fall, even if CSN is already low.

Decomposition:
- Shared package spi_pkg: SPI_WIDTH_DEFAULT=32, SPI mode constants (SPI_MODE0), state enum (IDLE, ACTIVE).
- One sub-module, spi_pin_sync: a SYNC_STAGES synchroniser plus history flop, with rise and fall pulse outputs. Instantiated three times: sclk, csn, mosi (mosi uses the level only).

Test Plan:
- Basic exchange: TX buffer loaded with 0xA5A5_0F0F. Master sends 0x1234_5678 (sclk=clk/8) -> MISO returns 0xA5A5_0F0F; rx_data=0x1234_5678 with rx_valid=1 within 4 clk of the final sclk rise; tx_ready=1 from CSN fall.
- Back-to-back words: two words with CSN held low; buffer reloaded with 0xDEAD_BEEF between them; rx_ack after each word -> second MISO word is 0xDEAD_BEEF, no overrun, no underrun.
- Underrun/overrun: no TX load, two words, no rx_ack -> MISO all zeros; underrun=1; overrun=1 after word 2; rx_data=word 2. status_clr -> both flags 0.
- Abort: CSN raised after 13 bits -> rx_valid unchanged, count reset. A following full word 0x0000_0001 is received correctly.
- Simultaneous events: rx_ack in the completion cycle -> rx_valid=1, overrun=0. tx_load in the reload cycle with the buffer empty -> underrun=1, tx_ready=0, next word transmits the loaded value.
- Reset mid-frame: reset asserted after 8 bits with CSN still low -> all outputs at reset values. Remaining sclk pulses are ignored until CSN goes high then low, after which a full word is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: default word length, SPI mode
// encoding and the frame state machine states.
package spi_pkg;

  localparam int SPI_WIDTH_DEFAULT = 32;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t SPI_MODE0 = '{cpol: 1'b0, cpha: 1'b0};

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

endpackage : spi_pkg

// File: rtl/spi_slave_port_if.sv
// Bundle of SPI pins plus the word-level core handshake for spi_slave_port.
// The slave modport is the responder's view; master is the host/core side.
interface spi_slave_port_if #(
  parameter int WIDTH = spi_pkg::SPI_WIDTH_DEFAULT
);
  logic             spi_sclk;
  logic             spi_csn;
  logic             spi_mosi;
  logic             spi_miso;
  logic             spi_miso_oe;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ack;
  logic [WIDTH-1:0] tx_data;
  logic             tx_load;
  logic             tx_ready;
  logic             overrun;
  logic             underrun;
  logic             status_clr;

  modport slave (
    input  spi_sclk, spi_csn, spi_mosi, rx_ack, tx_data, tx_load, status_clr,
    output spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready, overrun, underrun
  );

  modport master (
    output spi_sclk, spi_csn, spi_mosi, rx_ack, tx_data, tx_load, status_clr,
    input  spi_miso, spi_miso_oe, rx_data, rx_valid, tx_ready, overrun, underrun
  );

endinterface : spi_slave_port_if

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with a history flop
// producing single-cycle rise/fall pulses in the clk domain.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic [SYNC_STAGES:0]   r_fill;
  logic                   w_valid;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes the chain a chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= {SYNC_STAGES{IDLE_LEVEL}};
      r_hist <= IDLE_LEVEL;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_hist <= r_sync[SYNC_STAGES-1];
      r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Edges are suppressed until the chain and history hold real pin samples,
  // so a pin that already sits away from its idle level at reset release
  // does not produce a phantom edge.
  assign w_valid = r_fill[SYNC_STAGES];
  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = w_valid &&  o_level && !r_hist;
  assign o_fall  = w_valid && !o_level &&  r_hist;

endmodule : spi_pin_sync

// File: rtl/spi_slave_port.sv
// SPI mode-0 responder, fully oversampled in the clk domain. Presents a
// word-level RX register and a one-deep TX buffer to the core.
module spi_slave_port
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  spi_slave_port_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  spi_state_e       r_state, w_state_next;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-2:0] r_rx_shift;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic [WIDTH-1:0] r_tx_buf;
  logic             r_tx_ready;
  logic [WIDTH-1:0] r_tx_shift;
  logic             r_overrun;
  logic             r_underrun;

  logic w_sclk_rise, w_sclk_fall, w_sclk_level_unused;
  logic w_csn_rise, w_csn_fall, w_csn_level_unused;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;
  logic w_start, w_stop, w_bit_rise, w_bit_fall, w_word_done, w_reload;
  logic w_tx_accept, w_ur_set, w_or_set;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .i_pin(bus.spi_sclk),
    .o_level(w_sclk_level_unused), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_csn (
    .clk(clk), .reset(reset), .i_pin(bus.spi_csn),
    .o_level(w_csn_level_unused), .o_rise(w_csn_rise), .o_fall(w_csn_fall)
  );

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .i_pin(bus.spi_mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_stop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_csn_fall) begin
          w_state_next = ACTIVE;
          w_start      = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_csn_rise) begin
          w_state_next = IDLE;
          w_stop       = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase

    w_bit_rise  = (r_state == ACTIVE) && !w_stop && w_sclk_rise;
    w_bit_fall  = (r_state == ACTIVE) && !w_stop && w_sclk_fall && (r_count != '0);
    w_word_done = w_bit_rise && (r_count == CNT_W'(WIDTH - 1));
    w_reload    = w_start || w_word_done;
    w_tx_accept = bus.tx_load && r_tx_ready;
    w_ur_set    = w_reload && r_tx_ready;
    w_or_set    = w_word_done && r_rx_valid && !bus.rx_ack;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_tx_buf   <= '0;
      r_tx_ready <= 1'b1;
      r_tx_shift <= '0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_start || w_stop || w_word_done) r_count <= '0;
      else if (w_bit_rise)                  r_count <= r_count + 1'b1;

      if (w_bit_rise) r_rx_shift <= {r_rx_shift[WIDTH-3:0], w_mosi};

      // A completing word beats a same-cycle rx_ack: the new word stays valid.
      if (w_word_done) begin
        r_rx_data  <= {r_rx_shift, w_mosi};
        r_rx_valid <= 1'b1;
      end else if (bus.rx_ack) begin
        r_rx_valid <= 1'b0;
      end

      // Full buffer moves into the shifter; an empty one sends zeros and
      // leaves the buffer free to accept a same-cycle tx_load.
      if (w_reload) r_tx_shift <= r_tx_ready ? '0 : r_tx_buf;
      else if (w_bit_fall) r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};

      if (w_tx_accept) r_tx_buf <= bus.tx_data;

      if (w_reload && !r_tx_ready) r_tx_ready <= 1'b1;
      else if (w_tx_accept)        r_tx_ready <= 1'b0;

      if (w_or_set)            r_overrun <= 1'b1;
      else if (bus.status_clr) r_overrun <= 1'b0;

      if (w_ur_set)            r_underrun <= 1'b1;
      else if (bus.status_clr) r_underrun <= 1'b0;
    end
  end

  assign bus.spi_miso    = (r_state == ACTIVE) && r_tx_shift[WIDTH-1];
  assign bus.spi_miso_oe = (r_state == ACTIVE);
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = r_rx_valid;
  assign bus.tx_ready    = r_tx_ready;
  assign bus.overrun     = r_overrun;
  assign bus.underrun    = r_underrun;

endmodule : spi_slave_port

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: acts as a mode-0 SPI master at clk/8 and
// as the core, checking each step against hand-computed values.
module tb_spi_slave_port;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [31:0] miso_w;

  spi_slave_port_if #(.WIDTH(32)) bus ();

  spi_slave_port #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_load(input logic [31:0] data);
    bus.tx_data = data;
    bus.tx_load = 1'b1;
    tick(1);
    bus.tx_load = 1'b0;
  endtask

  task automatic pulse_ack();
    bus.rx_ack = 1'b1;
    tick(1);
    bus.rx_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.status_clr = 1'b1;
    tick(1);
    bus.status_clr = 1'b0;
  endtask

  task automatic frame_begin();
    bus.spi_csn = 1'b0;
    tick(4);
  endtask

  task automatic frame_end();
    tick(4);
    bus.spi_csn = 1'b1;
    tick(6);
  endtask

  // Shifts nbits MSB-first; sclk low 4 clk, high 4 clk. inj = {clr, load, ack}
  // is driven in the clk cycle where the DUT acts on the last sclk rise.
  task automatic xfer(input logic [31:0] mosi_w, input int nbits,
                      input logic [2:0] inj, input logic [31:0] inj_data,
                      output logic [31:0] miso_o);
    miso_o = '0;
    for (int i = 0; i < nbits; i++) begin
      bus.spi_mosi = mosi_w[31-i];
      tick(4);
      miso_o = {miso_o[30:0], bus.spi_miso};
      bus.spi_sclk = 1'b1;
      if (i == nbits - 1 && inj != 3'b000) begin
        tick(2);
        bus.rx_ack     = inj[0];
        bus.tx_load    = inj[1];
        bus.tx_data    = inj_data;
        bus.status_clr = inj[2];
        tick(1);
        bus.rx_ack     = 1'b0;
        bus.tx_load    = 1'b0;
        bus.status_clr = 1'b0;
        tick(1);
      end else begin
        tick(4);
      end
      bus.spi_sclk = 1'b0;
    end
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset          = 1'b1;
    bus.spi_sclk   = 1'b0;
    bus.spi_csn    = 1'b1;
    bus.spi_mosi   = 1'b0;
    bus.rx_ack     = 1'b0;
    bus.tx_data    = '0;
    bus.tx_load    = 1'b0;
    bus.status_clr = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(4);

    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_tx_ready", bus.tx_ready, 1);
    check("rst_flags", {bus.overrun, bus.underrun}, 0);
    check("rst_miso", {bus.spi_miso, bus.spi_miso_oe}, 0);

    // Basic exchange
    pulse_load(32'hA5A5_0F0F);
    check("basic_tx_full", bus.tx_ready, 0);
    frame_begin();
    check("basic_tx_ready_on_cs", bus.tx_ready, 1);
    check("basic_miso_oe", bus.spi_miso_oe, 1);
    check("basic_underrun", bus.underrun, 0);
    xfer(32'h1234_5678, 32, 3'b000, 0, miso_w);
    check("basic_miso_word", miso_w, 32'hA5A5_0F0F);
    check("basic_rx_valid", bus.rx_valid, 1);
    check("basic_rx_data", bus.rx_data, 32'h1234_5678);
    frame_end();
    check("basic_oe_off", bus.spi_miso_oe, 0);
    pulse_ack();
    check("basic_ack_clears", bus.rx_valid, 0);
    pulse_clr();

    // Back-to-back words with CSN held low
    pulse_load(32'hCAFE_0001);
    frame_begin();
    pulse_load(32'hDEAD_BEEF);
    check("b2b_buf_full", bus.tx_ready, 0);
    xfer(32'h1111_1111, 32, 3'b000, 0, miso_w);
    check("b2b_miso_w1", miso_w, 32'hCAFE_0001);
    check("b2b_rx_w1", bus.rx_data, 32'h1111_1111);
    pulse_ack();
    pulse_load(32'h0BAD_F00D);
    xfer(32'h2222_2222, 32, 3'b000, 0, miso_w);
    check("b2b_miso_w2", miso_w, 32'hDEAD_BEEF);
    check("b2b_rx_w2", bus.rx_data, 32'h2222_2222);
    check("b2b_flags", {bus.overrun, bus.underrun}, 0);
    pulse_ack();
    frame_end();

    // Underrun and overrun
    frame_begin();
    check("uo_underrun_start", bus.underrun, 1);
    xfer(32'h0F0F_0F0F, 32, 3'b000, 0, miso_w);
    check("uo_miso_w1", miso_w, 0);
    check("uo_no_overrun_w1", bus.overrun, 0);
    xfer(32'hF0F0_F0F0, 32, 3'b000, 0, miso_w);
    check("uo_miso_w2", miso_w, 0);
    check("uo_overrun_w2", bus.overrun, 1);
    check("uo_rx_data_w2", bus.rx_data, 32'hF0F0_F0F0);
    frame_end();
    pulse_clr();
    check("uo_clr", {bus.overrun, bus.underrun}, 0);

    // Abort after 13 bits, then a clean word
    pulse_load(32'h5555_5555);
    frame_begin();
    check("abort_no_underrun", bus.underrun, 0);
    xfer(32'hAAAA_AAAA, 13, 3'b000, 0, miso_w);
    check("abort_partial_miso", miso_w, 32'h0000_0AAA);
    frame_end();
    check("abort_rx_valid_kept", bus.rx_valid, 1);
    check("abort_rx_data_kept", bus.rx_data, 32'hF0F0_F0F0);
    check("abort_no_flags", {bus.overrun, bus.underrun}, 0);
    pulse_ack();
    pulse_load(32'h8000_0001);
    frame_begin();
    xfer(32'h0000_0001, 32, 3'b000, 0, miso_w);
    check("after_abort_miso", miso_w, 32'h8000_0001);
    check("after_abort_rx_data", bus.rx_data, 32'h0000_0001);
    check("after_abort_rx_valid", bus.rx_valid, 1);
    check("after_abort_overrun", bus.overrun, 0);
    frame_end();
    pulse_clr();

    // Same-cycle events at word completion: ack, load into empty buffer, clr
    check("sim_pre_underrun", bus.underrun, 0);
    pulse_load(32'h1212_1212);
    frame_begin();
    check("sim_start_underrun", bus.underrun, 0);
    xfer(32'h600D_CAFE, 32, 3'b111, 32'h3C3C_3C3C, miso_w);
    check("sim_miso", miso_w, 32'h1212_1212);
    check("sim_rx_valid", bus.rx_valid, 1);
    check("sim_rx_data", bus.rx_data, 32'h600D_CAFE);
    check("sim_overrun", bus.overrun, 0);
    check("sim_underrun_set_wins", bus.underrun, 1);
    check("sim_tx_ready", bus.tx_ready, 0);
    frame_end();
    pulse_clr();
    pulse_ack();
    frame_begin();
    check("sim_next_tx_ready", bus.tx_ready, 1);
    check("sim_next_underrun", bus.underrun, 0);
    xfer(32'hC3C3_C3C3, 32, 3'b000, 0, miso_w);
    check("sim_next_miso", miso_w, 32'h3C3C_3C3C);
    frame_end();

    // Reset mid-frame with CSN held low
    pulse_load(32'h7777_7777);
    frame_begin();
    xfer(32'hFFFF_FFFF, 8, 3'b000, 0, miso_w);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    check("mid_rst_rx_data", bus.rx_data, 0);
    check("mid_rst_rx_valid", bus.rx_valid, 0);
    check("mid_rst_tx_ready", bus.tx_ready, 1);
    check("mid_rst_flags", {bus.overrun, bus.underrun}, 0);
    check("mid_rst_miso", {bus.spi_miso, bus.spi_miso_oe}, 0);
    xfer(32'hFFFF_FFFF, 24, 3'b000, 0, miso_w);
    check("mid_rst_ignored_oe", bus.spi_miso_oe, 0);
    check("mid_rst_ignored_valid", bus.rx_valid, 0);
    frame_end();
    frame_begin();
    check("mid_rst_new_frame_oe", bus.spi_miso_oe, 1);
    check("mid_rst_new_underrun", bus.underrun, 1);
    xfer(32'h9ABC_DEF0, 32, 3'b000, 0, miso_w);
    check("mid_rst_new_miso", miso_w, 0);
    check("mid_rst_new_rx_data", bus.rx_data, 32'h9ABC_DEF0);
    check("mid_rst_new_rx_valid", bus.rx_valid, 1);
    frame_end();
    check("mid_rst_end_oe", bus.spi_miso_oe, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_spi_slave_port
